// File: rtl/video_tg_pkg.sv
// Shared types and constants for the video timing generator.
package video_tg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRONT,
        ST_LINE,
        ST_HBLANK,
        ST_BACK,
        ST_VBLANK
    } tg_state_e;

    localparam logic [1:0] PAT_PIX_INC   = 2'd0;
    localparam logic [1:0] PAT_H_RAMP    = 2'd1;
    localparam logic [1:0] PAT_V_RAMP    = 2'd2;
    localparam logic [1:0] PAT_FRAME_NUM = 2'd3;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Control inputs and sensor-style video outputs of the timing generator.
interface video_timing_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_enable;
    logic [1:0]            iv_pattern_sel;
    logic                  o_fval;
    logic                  o_lval;
    logic [DATA_WIDTH-1:0] ov_dout;
    logic                  o_frame_done;
    logic [15:0]           ov_frame_cnt;

    modport master (
        input  i_enable,
        input  iv_pattern_sel,
        output o_fval,
        output o_lval,
        output ov_dout,
        output o_frame_done,
        output ov_frame_cnt
    );

    modport slave (
        output i_enable,
        output iv_pattern_sel,
        input  o_fval,
        input  o_lval,
        input  ov_dout,
        input  o_frame_done,
        input  ov_frame_cnt
    );
endinterface

// File: rtl/tg_pattern_mux.sv
// Selects the test-pattern pixel value from the current frame position.
module tg_pattern_mux
    import video_tg_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COL_W      = 1,
    parameter int LINE_W     = 1
) (
    input  logic [1:0]            pattern_sel,
    input  logic [COL_W-1:0]      col,
    input  logic [LINE_W-1:0]     line,
    input  logic [DATA_WIDTH-1:0] pix_cnt,
    input  logic [15:0]           frame_cnt,
    output logic [DATA_WIDTH-1:0] data
);

    // Casts truncate modulo 2^DATA_WIDTH or zero-extend as needed.
    always_comb begin
        data = '0;
        case (pattern_sel)
            PAT_PIX_INC:   data = pix_cnt;
            PAT_H_RAMP:    data = DATA_WIDTH'(col);
            PAT_V_RAMP:    data = DATA_WIDTH'(line);
            PAT_FRAME_NUM: data = DATA_WIDTH'(frame_cnt);
            default:       data = '0;
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// Frame/line timing generator with selectable test patterns; outputs are
// registered from next-state values so fval, lval and dout stay aligned.
module video_timing_gen
    import video_tg_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int H_ACTIVE   = 2592,
    parameter int H_BLANK    = 32,
    parameter int V_ACTIVE   = 1944,
    parameter int V_FRONT    = 4,
    parameter int V_BACK     = 4,
    parameter int V_BLANK    = 64
) (
    input  logic clk,
    input  logic reset_n,
    video_timing_gen_if.master tg
);

    localparam int COL_W   = cnt_w(H_ACTIVE);
    localparam int LINE_W  = cnt_w(V_ACTIVE);
    localparam int BLK_M1  = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
    localparam int BLK_M2  = (V_BACK > V_BLANK) ? V_BACK : V_BLANK;
    localparam int BLK_MAX = (BLK_M1 > BLK_M2) ? BLK_M1 : BLK_M2;
    localparam int BLK_W   = cnt_w(BLK_MAX);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_ACTIVE - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);
    localparam logic [BLK_W-1:0]  FRONT_END = BLK_W'(V_FRONT - 1);
    localparam logic [BLK_W-1:0]  HBLK_END  = BLK_W'(H_BLANK - 1);
    localparam logic [BLK_W-1:0]  BACK_END  = BLK_W'(V_BACK - 1);
    localparam logic [BLK_W-1:0]  VBLK_END  = BLK_W'(V_BLANK - 1);

    tg_state_e             state_p0, state_p1;
    logic [COL_W-1:0]      col_p0, col_p1;
    logic [LINE_W-1:0]     line_p0, line_p1;
    logic [BLK_W-1:0]      blk_p0, blk_p1;
    logic [DATA_WIDTH-1:0] pix_p0, pix_p1;
    logic [1:0]            sel_p0, sel_p1;
    logic                  start_frame;
    logic                  done_p0, done_p1;
    logic                  fval_p0, fval_p1;
    logic                  vld_p0, vld_p1;
    logic [DATA_WIDTH-1:0] pat_p0;
    logic [DATA_WIDTH-1:0] dout_p0, dout_p1;
    logic [15:0]           frame_cnt_p1;

    // Stage p0: next-state, counter and pattern computation
    always_comb begin
        state_p0    = state_p1;
        col_p0      = col_p1;
        line_p0     = line_p1;
        blk_p0      = blk_p1;
        pix_p0      = pix_p1;
        sel_p0      = sel_p1;
        start_frame = 1'b0;
        done_p0     = 1'b0;
        case (state_p1)
            ST_IDLE: begin
                if (tg.i_enable) start_frame = 1'b1;
            end
            ST_FRONT: begin
                if (blk_p1 == FRONT_END) begin
                    state_p0 = ST_LINE;
                    blk_p0   = '0;
                end else begin
                    blk_p0 = blk_p1 + 1'b1;
                end
            end
            ST_LINE: begin
                pix_p0 = pix_p1 + 1'b1;
                if (col_p1 == COL_LAST) begin
                    col_p0 = '0;
                    if (line_p1 == LINE_LAST) begin
                        state_p0 = ST_BACK;
                    end else begin
                        state_p0 = ST_HBLANK;
                        line_p0  = line_p1 + 1'b1;
                    end
                end else begin
                    col_p0 = col_p1 + 1'b1;
                end
            end
            ST_HBLANK: begin
                if (blk_p1 == HBLK_END) begin
                    state_p0 = ST_LINE;
                    blk_p0   = '0;
                end else begin
                    blk_p0 = blk_p1 + 1'b1;
                end
            end
            ST_BACK: begin
                if (blk_p1 == BACK_END) begin
                    state_p0 = ST_VBLANK;
                    blk_p0   = '0;
                    done_p0  = 1'b1;
                end else begin
                    blk_p0 = blk_p1 + 1'b1;
                end
            end
            ST_VBLANK: begin
                if (blk_p1 == VBLK_END) begin
                    blk_p0 = '0;
                    if (tg.i_enable) start_frame = 1'b1;
                    else             state_p0    = ST_IDLE;
                end else begin
                    blk_p0 = blk_p1 + 1'b1;
                end
            end
            default: state_p0 = ST_IDLE;
        endcase
        // Every frame starts from pixel/line 0 with a freshly latched pattern.
        if (start_frame) begin
            state_p0 = ST_FRONT;
            col_p0   = '0;
            line_p0  = '0;
            blk_p0   = '0;
            pix_p0   = '0;
            sel_p0   = tg.iv_pattern_sel;
        end
    end

    assign fval_p0 = (state_p0 == ST_FRONT) || (state_p0 == ST_LINE) ||
                     (state_p0 == ST_HBLANK) || (state_p0 == ST_BACK);
    assign vld_p0  = (state_p0 == ST_LINE);
    assign dout_p0 = vld_p0 ? pat_p0 : '0;

    tg_pattern_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .COL_W      (COL_W),
        .LINE_W     (LINE_W)
    ) u_pattern_mux (
        .pattern_sel (sel_p0),
        .col         (col_p0),
        .line        (line_p0),
        .pix_cnt     (pix_p0),
        .frame_cnt   (frame_cnt_p1),
        .data        (pat_p0)
    );

    // Stage p1: state, counters and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_p1     <= ST_IDLE;
            col_p1       <= '0;
            line_p1      <= '0;
            blk_p1       <= '0;
            pix_p1       <= '0;
            sel_p1       <= '0;
            fval_p1      <= 1'b0;
            vld_p1       <= 1'b0;
            dout_p1      <= '0;
            done_p1      <= 1'b0;
            frame_cnt_p1 <= '0;
        end else begin
            state_p1 <= state_p0;
            col_p1   <= col_p0;
            line_p1  <= line_p0;
            blk_p1   <= blk_p0;
            pix_p1   <= pix_p0;
            sel_p1   <= sel_p0;
            fval_p1  <= fval_p0;
            vld_p1   <= vld_p0;
            dout_p1  <= dout_p0;
            done_p1  <= done_p0;
            if (done_p0) frame_cnt_p1 <= frame_cnt_p1 + 16'd1;
        end
    end

    assign tg.o_fval       = fval_p1;
    assign tg.o_lval       = vld_p1;
    assign tg.ov_dout      = dout_p1;
    assign tg.o_frame_done = done_p1;
    assign tg.ov_frame_cnt = frame_cnt_p1;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a small 4x3 configuration plus a
// narrow-data instance that exercises pixel-counter wrap.
module tb_video_timing_gen;
    import video_tg_pkg::*;

    localparam int FVAL_LEN = 2 + 3*4 + 2*2 + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    video_timing_gen_if #(.DATA_WIDTH(8)) vif ();
    video_timing_gen_if #(.DATA_WIDTH(4)) vif2 ();

    video_timing_gen #(
        .DATA_WIDTH(8), .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3),
        .V_FRONT(2), .V_BACK(1), .V_BLANK(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tg(vif)
    );

    video_timing_gen #(
        .DATA_WIDTH(4), .H_ACTIVE(20), .H_BLANK(2), .V_ACTIVE(2),
        .V_FRONT(1), .V_BACK(1), .V_BLANK(2)
    ) dut_w4 (
        .clk(clk), .reset_n(reset_n), .tg(vif2)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [3:0] exp2_q[$];
    bit   gap_chk = 1'b0;
    bit   done2 = 1'b0;
    int   exp_cnt = 0;
    logic prev_fval = 1'b0;
    int   high_run = 0;
    int   low_run = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int sel, input int fnum);
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < 4; c++) begin
                int v;
                case (sel)
                    0: v = l*4 + c;
                    1: v = c;
                    2: v = l;
                    default: v = fnum;
                endcase
                exp_q.push_back(8'(v));
            end
    endtask

    task automatic wait_fval(input logic lvl, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (vif.o_fval !== lvl && n < 100);
        if (vif.o_fval !== lvl) begin
            checks++;
            errors++;
            $display("FAIL %s: fval stayed %0b, expected %0b within 100 cycles", nm, vif.o_fval, lvl);
        end
    endtask

    // Monitor for the main instance: pixels, frame_done alignment, run lengths
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_fval = 1'b0;
            high_run  = 0;
            low_run   = 0;
            exp_cnt   = 0;
        end else begin
            logic fell;
            fell = prev_fval && !vif.o_fval;
            if (vif.o_lval) begin
                check("lval_inside_fval", {31'd0, vif.o_fval}, 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got 0x%0h, expected no pixel", vif.ov_dout);
                end else begin
                    check("pixel", {24'd0, vif.ov_dout}, {24'd0, exp_q.pop_front()});
                end
            end else begin
                check("dout_zero_when_idle", {24'd0, vif.ov_dout}, 32'd0);
            end
            if (fell || vif.o_frame_done) begin
                check("frame_done_at_fval_fall", {31'd0, vif.o_frame_done}, {31'd0, fell});
                check("frame_cnt_on_done", {16'd0, vif.ov_frame_cnt}, 32'(16'(exp_cnt + 1)));
                check("fval_high_len", high_run, FVAL_LEN);
                exp_cnt = exp_cnt + 1;
            end
            if (vif.o_fval) begin
                if (!prev_fval && gap_chk) check("vblank_len", low_run, 3);
                high_run++;
                low_run = 0;
            end else begin
                high_run = 0;
                low_run++;
            end
            prev_fval = vif.o_fval;
        end
    end

    // Monitor for the narrow-data instance
    always @(negedge clk) begin
        if (reset_n && vif2.o_lval) begin
            if (exp2_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel_w4: got 0x%0h, expected no pixel", vif2.ov_dout);
            end else begin
                check("pixel_w4", {28'd0, vif2.ov_dout}, {28'd0, exp2_q.pop_front()});
            end
        end
    end

    initial begin
        int n;
        vif2.i_enable       = 1'b0;
        vif2.iv_pattern_sel = PAT_PIX_INC;
        wait (reset_n === 1'b1);
        for (int i = 0; i < 40; i++) exp2_q.push_back(4'(i % 16));
        @(negedge clk); #2;
        vif2.i_enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (vif2.o_fval !== 1'b1 && n < 100);
        #2 vif2.i_enable = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (vif2.o_frame_done !== 1'b1 && n < 200);
        check("frame_cnt_w4", {16'd0, vif2.ov_frame_cnt}, 32'd1);
        done2 = 1'b1;
    end

    initial begin
        int k, n;
        logic pl;
        vif.i_enable       = 1'b0;
        vif.iv_pattern_sel = PAT_PIX_INC;
        repeat (2) @(negedge clk);
        #1;
        check("rst_fval", {31'd0, vif.o_fval}, 32'd0);
        check("rst_lval", {31'd0, vif.o_lval}, 32'd0);
        check("rst_dout", {24'd0, vif.ov_dout}, 32'd0);
        check("rst_frame_done", {31'd0, vif.o_frame_done}, 32'd0);
        check("rst_frame_cnt", {16'd0, vif.ov_frame_cnt}, 32'd0);
        @(negedge clk); #2;
        reset_n = 1'b1;

        // Three frame-number frames, then pattern 0/1/2 with mid-frame sel changes
        push_frame(3, 0);
        vif.iv_pattern_sel = PAT_FRAME_NUM;
        vif.i_enable = 1'b1;
        wait_fval(1'b1, "f0_rise");
        wait_fval(1'b0, "f0_fall");
        #2 gap_chk = 1'b1;
        push_frame(3, 1);
        wait_fval(1'b1, "f1_rise");
        wait_fval(1'b0, "f1_fall");
        #2 push_frame(3, 2);
        wait_fval(1'b1, "f2_rise");
        wait_fval(1'b0, "f2_fall");
        check("frame_cnt_after_3", {16'd0, vif.ov_frame_cnt}, 32'd3);
        #2 vif.iv_pattern_sel = PAT_PIX_INC;
        push_frame(0, 0);
        wait_fval(1'b1, "f3_rise");
        #2 vif.iv_pattern_sel = PAT_H_RAMP;
        push_frame(1, 0);
        wait_fval(1'b0, "f3_fall");
        wait_fval(1'b1, "f4_rise");
        #2 vif.iv_pattern_sel = PAT_V_RAMP;
        push_frame(2, 0);
        wait_fval(1'b0, "f4_fall");
        wait_fval(1'b1, "f5_rise");

        // Drop enable on the fifth active pixel; the frame must still complete
        k = 0;
        n = 0;
        while (k < 5 && n < 100) begin
            @(negedge clk);
            n++;
            if (vif.o_lval) k++;
        end
        check("fifth_pixel_seen", k, 5);
        #2 vif.i_enable = 1'b0;
        gap_chk = 1'b0;
        wait_fval(1'b0, "f5_fall");
        k = 0;
        repeat (30) begin
            @(negedge clk);
            if (vif.o_fval) k++;
        end
        check("idle_after_disable", k, 0);
        check("frame_cnt_after_6", {16'd0, vif.ov_frame_cnt}, 32'd6);

        // Asynchronous reset during the second line
        #2 vif.iv_pattern_sel = PAT_PIX_INC;
        push_frame(0, 0);
        vif.i_enable = 1'b1;
        wait_fval(1'b1, "rst_frame_rise");
        k = 0;
        n = 0;
        pl = 1'b0;
        while (k < 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (vif.o_lval && !pl) k++;
            pl = vif.o_lval;
        end
        check("line2_reached", k, 2);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_fval", {31'd0, vif.o_fval}, 32'd0);
        check("async_rst_lval", {31'd0, vif.o_lval}, 32'd0);
        check("async_rst_dout", {24'd0, vif.ov_dout}, 32'd0);
        check("async_rst_frame_done", {31'd0, vif.o_frame_done}, 32'd0);
        check("async_rst_frame_cnt", {16'd0, vif.ov_frame_cnt}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("rst_hold_frame_done", {31'd0, vif.o_frame_done}, 32'd0);
        push_frame(0, 0);
        #2 reset_n = 1'b1;
        wait_fval(1'b1, "post_rst_rise");
        check("frame_cnt_post_rst", {16'd0, vif.ov_frame_cnt}, 32'd0);
        #2 vif.i_enable = 1'b0;
        wait_fval(1'b0, "post_rst_fall");
        check("frame_cnt_post_rst_done", {16'd0, vif.ov_frame_cnt}, 32'd1);

        n = 0;
        while (!done2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("w4_frame_finished", {31'd0, done2}, 32'd1);
        check("queue_drained", exp_q.size(), 0);
        check("queue_w4_drained", exp2_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel data width in bits; legal range 1..32.
REQ-002 Parameter H_ACTIVE, default 2592: pixels per line (lval high cycles); minimum 1.
REQ-003 Parameter H_BLANK, default 32: lval-low cycles between consecutive lines inside a frame; minimum 1.
REQ-004 Parameter V_ACTIVE, default 1944: lines per frame; minimum 1.
REQ-005 Parameter V_FRONT, default 4: fval-high, lval-low cycles before the first line; minimum 1.
REQ-006 Parameter V_BACK, default 4: fval-high, lval-low cycles after the last line; minimum 1.
REQ-007 Parameter V_BLANK, default 64: fval-low cycles between frames; minimum 1.
REQ-008 clk  input  1  sole clock; all logic on its rising edge.
REQ-009 reset_n  input  1  asynchronous, active-low reset.
REQ-010 i_enable  input  1  level; 1 = generate frames continuously.
REQ-011 iv_pattern_sel  input  2  pattern select: 0 pixel increment, 1 horizontal ramp, 2 vertical ramp, 3 frame-number fill.
REQ-012 o_fval  output  1  frame valid.
REQ-013 o_lval  output  1  line valid.
REQ-014 ov_dout  output  DATA_WIDTH  pixel data; valid only while o_lval=1.
REQ-015 o_frame_done  output  1  one-cycle pulse on the cycle o_fval falls.
REQ-016 ov_frame_cnt  output  16  count of completed frames.

Function
REQ-017 The FSM SHALL have states IDLE, FRONT, LINE, HBLANK, BACK and VBLANK.
REQ-018 IDLE: fval=0, lval=0; leave to FRONT on the first cycle i_enable=1.
REQ-019 FRONT: fval=1, lval=0 for V_FRONT cycles, then LINE.
REQ-020 LINE: fval=1, lval=1 for H_ACTIVE cycles; then HBLANK if lines remain, else BACK (no HBLANK after the last line).
REQ-021 HBLANK: fval=1, lval=0 for H_BLANK cycles, then LINE.
REQ-022 BACK: fval=1, lval=0 for V_BACK cycles, then VBLANK.
REQ-023 VBLANK: fval=0, lval=0 for V_BLANK cycles; at its end, go to FRONT if i_enable=1, else IDLE.
REQ-024 i_enable SHALL be sampled only in IDLE and on the final VBLANK cycle; deassertion mid-frame completes the current frame and its VBLANK.
REQ-025 All outputs SHALL be registered; each output reflects the state of the same cycle, with no extra pipeline skew between fval, lval and dout.
REQ-026 iv_pattern_sel SHALL be latched on entry to FRONT and held for the whole frame.
REQ-027 Pattern 0: dout starts at 0 on the first pixel of the frame, increments by 1 per valid pixel across lines, and wraps modulo 2^DATA_WIDTH.
REQ-028 Pattern 1: dout = pixel column index (0..H_ACTIVE-1) modulo 2^DATA_WIDTH.
REQ-029 Pattern 2: dout = line index (0..V_ACTIVE-1) modulo 2^DATA_WIDTH.
REQ-030 Pattern 3: dout = ov_frame_cnt[DATA_WIDTH-1:0], zero-extended when DATA_WIDTH > 16.
REQ-031 ov_dout SHALL be 0 whenever o_lval=0.
REQ-032 ov_frame_cnt SHALL increment by 1 in the same cycle o_frame_done is 1, and wrap from 0xFFFF to 0.
REQ-033 fval-high duration SHALL be exactly V_FRONT + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + V_BACK cycles.
REQ-034 Counters SHALL be sized by $clog2 of their parameter, with a minimum width of 1.

Reset
REQ-035 While reset_n=0, the block SHALL be held in IDLE with o_fval=0, o_lval=0, ov_dout=0, o_frame_done=0, ov_frame_cnt=0, all counters 0 and the latched pattern select 0.
REQ-036 Reset assertion mid-frame SHALL drop fval and lval asynchronously with no o_frame_done pulse; after release, the next frame starts from the pixel-0 and line-0 indices.

Structure
REQ-037 Package video_tg_pkg SHALL hold the state enumeration and the four pattern-select code constants.
REQ-038 The pattern datapath SHALL be a single sub-module, tg_pattern_mux (pattern_sel, col, line, pix_cnt, frame_cnt -> data); timing and counters stay in video_timing_gen.

Verification (parameters H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_FRONT=2, V_BACK=1, V_BLANK=3, DATA_WIDTH=8)
REQ-039 Enable held at 1, sel=0 -> fval high for 19 cycles and low for 3 (period 22); 3 lval bursts of 4 with 2-cycle gaps; dout 0..11 across the frame.
REQ-040 sel=1, then sel=2 -> per line dout 0,1,2,3; then line-constant dout 0,1,2; sel changed mid-frame does not affect the current frame.
REQ-041 sel=3 over 3 frames -> frame data 0x00, 0x01, 0x02; o_frame_done pulses once per frame, aligned with fval fall; ov_frame_cnt ends at 3.
REQ-042 Enable dropped at the 5th lval-high cycle -> frame completes normally (19 fval-high cycles), VBLANK completes, block returns to IDLE with fval=0.
REQ-043 reset_n pulsed low during line 2 -> fval and lval drop immediately, no frame_done pulse; after release with enable=1 the next frame dout restarts at 0 and ov_frame_cnt=0.
REQ-044 DATA_WIDTH=4, H_ACTIVE=20, sel=0 -> dout wraps 15 -> 0 within line 1.
